// File: rtl/hbridge_gate_ctrl_pkg.sv
// Shared types and constants for the H-bridge gate controller.
package hbridge_gate_ctrl_pkg;

  // Per-leg gate state
  typedef enum logic [1:0] {
    LEG_OFF     = 2'd0,
    LEG_DEAD    = 2'd1,
    LEG_HIGH_ON = 2'd2,
    LEG_LOW_ON  = 2'd3
  } leg_state_e;

  // Shortest dead time the legs will ever insert, in clock cycles
  localparam int unsigned DT_MIN = 1;

endpackage : hbridge_gate_ctrl_pkg

// File: rtl/hbridge_gate_ctrl_dt_leg.sv
// One bridge leg: dead-time FSM driving a complementary high/low gate pair.
module hbridge_gate_ctrl_dt_leg
  import hbridge_gate_ctrl_pkg::*;
#(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk_50m,
  input  logic            rst,
  input  logic            cmd,
  input  logic            leg_en,
  input  logic [DT_W-1:0] dt_cycles,
  output logic            gh,
  output logic            gl
);

  leg_state_e      state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            gh_q, gh_d;
  logic            gl_q, gl_d;
  logic [DT_W-1:0] dt_eff_c;

  // Zero dead time is clamped to the minimum so the legs never cross directly
  always_comb begin
    dt_eff_c = dt_cycles;
    if (dt_cycles < DT_W'(DT_MIN)) begin
      dt_eff_c = DT_W'(DT_MIN);
    end
  end

  // Next-state and gate decode; loss of enable forces OFF from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!leg_en) begin
      state_d = LEG_OFF;
    end else begin
      case (state_q)
        LEG_OFF: begin
          state_d = LEG_DEAD;
          cnt_d   = dt_eff_c;
        end
        LEG_DEAD: begin
          if (cnt_q <= DT_W'(1)) begin
            state_d = cmd ? LEG_HIGH_ON : LEG_LOW_ON;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        LEG_HIGH_ON: begin
          if (!cmd) begin
            state_d = LEG_DEAD;
            cnt_d   = dt_eff_c;
          end
        end
        LEG_LOW_ON: begin
          if (cmd) begin
            state_d = LEG_DEAD;
            cnt_d   = dt_eff_c;
          end
        end
        default: begin
          state_d = LEG_OFF;
        end
      endcase
    end
    gh_d = (state_d == LEG_HIGH_ON);
    gl_d = (state_d == LEG_LOW_ON);
  end

  // State, counter and gate registers; reset parks the leg in DEAD
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= LEG_DEAD;
      cnt_q   <= dt_eff_c;
      gh_q    <= 1'b0;
      gl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gh_q    <= gh_d;
      gl_q    <= gl_d;
    end
  end

  assign gh = gh_q;
  assign gl = gl_q;

endmodule : hbridge_gate_ctrl_dt_leg

// File: rtl/hbridge_gate_ctrl.sv
// H-bridge gate controller: command register, fault filter/latch, two dead-time legs.
module hbridge_gate_ctrl
  import hbridge_gate_ctrl_pkg::*;
#(
  parameter int unsigned DT_W     = 8,
  parameter int unsigned FLT_FILT = 5,
  parameter int unsigned FLT_W    = 3
) (
  input  logic            clk_50m,
  input  logic            rst,
  input  logic            en,
  input  logic            spwm_a,
  input  logic            spwm_b,
  input  logic [DT_W-1:0] dt_cycles,
  input  logic            fault_n,
  input  logic            clear_fault,
  output logic            gate_ah,
  output logic            gate_al,
  output logic            gate_bh,
  output logic            gate_bl,
  output logic            fault_latched,
  output logic            running
);

  logic             cmd_a_q, cmd_a_d;
  logic             cmd_b_q, cmd_b_d;
  logic             flt_s1_q, flt_s1_d;
  logic             flt_s2_q, flt_s2_d;
  logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic             fault_latched_q, fault_latched_d;
  logic             running_q, running_d;
  logic             trip_c;
  logic             clear_ok_c;
  logic             leg_en_c;

  // Input capture, fault filter, latch and enable qualification
  always_comb begin
    cmd_a_d  = spwm_a;
    cmd_b_d  = spwm_b;
    flt_s1_d = fault_n;
    flt_s2_d = flt_s1_q;

    filt_cnt_d = filt_cnt_q;
    if (flt_s2_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q < FLT_W'(FLT_FILT)) begin
      filt_cnt_d = filt_cnt_q + FLT_W'(1);
    end

    trip_c     = !flt_s2_q && (filt_cnt_d == FLT_W'(FLT_FILT));
    clear_ok_c = clear_fault && flt_s2_q && (filt_cnt_q == '0);

    fault_latched_d = fault_latched_q;
    if (trip_c) begin
      fault_latched_d = 1'b1;
    end else if (clear_ok_c) begin
      fault_latched_d = 1'b0;
    end

    running_d = en && !fault_latched_q;
    leg_en_c  = en && !fault_latched_q && !trip_c;
  end

  // Top-level registers; synchroniser idles at the no-fault level
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cmd_a_q         <= 1'b0;
      cmd_b_q         <= 1'b0;
      flt_s1_q        <= 1'b1;
      flt_s2_q        <= 1'b1;
      filt_cnt_q      <= '0;
      fault_latched_q <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      cmd_a_q         <= cmd_a_d;
      cmd_b_q         <= cmd_b_d;
      flt_s1_q        <= flt_s1_d;
      flt_s2_q        <= flt_s2_d;
      filt_cnt_q      <= filt_cnt_d;
      fault_latched_q <= fault_latched_d;
      running_q       <= running_d;
    end
  end

  hbridge_gate_ctrl_dt_leg #(.DT_W(DT_W)) u_leg_a (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .cmd       (cmd_a_q),
    .leg_en    (leg_en_c),
    .dt_cycles (dt_cycles),
    .gh        (gate_ah),
    .gl        (gate_al)
  );

  hbridge_gate_ctrl_dt_leg #(.DT_W(DT_W)) u_leg_b (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .cmd       (cmd_b_q),
    .leg_en    (leg_en_c),
    .dt_cycles (dt_cycles),
    .gh        (gate_bh),
    .gl        (gate_bl)
  );

  assign fault_latched = fault_latched_q;
  assign running       = running_q;

  // Shoot-through guard: a leg must never drive both of its switches
  always_ff @(posedge clk_50m) begin
    assert (!(gate_ah && gate_al));
    assert (!(gate_bh && gate_bl));
  end

endmodule : hbridge_gate_ctrl

// File: tb/tb_hbridge_gate_ctrl.sv
// Scoreboard bench for hbridge_gate_ctrl: timed expectations plus per-cycle guards.
module tb_hbridge_gate_ctrl;

  localparam int unsigned DT_W = 8;

  logic            clk_50m = 1'b0;
  logic            rst, en, spwm_a, spwm_b, fault_n, clear_fault;
  logic [DT_W-1:0] dt_cycles;
  logic            gate_ah, gate_al, gate_bh, gate_bl, fault_latched, running;

  hbridge_gate_ctrl #(.DT_W(DT_W), .FLT_FILT(5), .FLT_W(3)) dut (
    .clk_50m       (clk_50m),
    .rst           (rst),
    .en            (en),
    .spwm_a        (spwm_a),
    .spwm_b        (spwm_b),
    .dt_cycles     (dt_cycles),
    .fault_n       (fault_n),
    .clear_fault   (clear_fault),
    .gate_ah       (gate_ah),
    .gate_al       (gate_al),
    .gate_bh       (gate_bh),
    .gate_bl       (gate_bl),
    .fault_latched (fault_latched),
    .running       (running)
  );

  always #10 clk_50m = ~clk_50m;

  // Signal ids for the scoreboard
  localparam int S_AH = 0, S_AL = 1, S_BH = 2, S_BL = 3, S_FL = 4, S_RUN = 5;

  typedef struct {
    int cyc;
    int tn;
    int id;
    bit val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   tn    = 0;
  bit   dt_mon = 1'b0;
  int   dead_min = 3;
  int   a_gap = 0, b_gap = 0;
  bit   a_prev_on = 1'b0, b_prev_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic sig_val(input int id);
    case (id)
      S_AH:    return gate_ah;
      S_AL:    return gate_al;
      S_BH:    return gate_bh;
      S_BL:    return gate_bl;
      S_FL:    return fault_latched;
      default: return running;
    endcase
  endfunction

  function automatic string sig_name(input int id);
    case (id)
      S_AH:    return "gate_ah";
      S_AL:    return "gate_al";
      S_BH:    return "gate_bh";
      S_BL:    return "gate_bl";
      S_FL:    return "fault_latched";
      default: return "running";
    endcase
  endfunction

  // Insert an expectation keeping the queue ordered by cycle
  function automatic void expect_at(input int c, input int id, input bit v);
    exp_t e;
    int   i = 0;
    e.cyc = c; e.tn = tn; e.id = id; e.val = v;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endfunction

  function automatic void expect_range(input int c0, input int c1, input int id, input bit v);
    for (int c = c0; c <= c1; c++) expect_at(c, id, v);
  endfunction

  function automatic void expect_all_off(input int c0, input int c1);
    for (int id = S_AH; id <= S_BL; id++) expect_range(c0, c1, id, 1'b0);
  endfunction

  // One clock: sample after the edge, run guards, retire due expectations
  task automatic tick();
    exp_t e;
    bit   on;
    @(posedge clk_50m);
    #1;
    cyc++;
    chk("mutex_a", 32'(gate_ah & gate_al), 32'd0);
    chk("mutex_b", 32'(gate_bh & gate_bl), 32'd0);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc)
        chk($sformatf("t%0d_missed_%s", e.tn, sig_name(e.id)), 32'(e.cyc), 32'(cyc));
      else
        chk($sformatf("t%0d_%s", e.tn, sig_name(e.id)), 32'(sig_val(e.id)), 32'(e.val));
    end
    on = gate_ah | gate_al;
    if (on) begin
      if (!a_prev_on && dt_mon) chk("dead_min_a", 32'(a_gap >= dead_min), 32'd1);
      a_gap = 0;
    end else a_gap++;
    a_prev_on = on;
    on = gate_bh | gate_bl;
    if (on) begin
      if (!b_prev_on && dt_mon) chk("dead_min_b", 32'(b_gap >= dead_min), 32'd1);
      b_gap = 0;
    end else b_gap++;
    b_prev_on = on;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int k;
    bit e_now;
    rst = 1'b1; en = 1'b1; spwm_a = 1'b1; spwm_b = 1'b0;
    dt_cycles = DT_W'(10); fault_n = 1'b1; clear_fault = 1'b0;

    // 1: reset release, first dead period of 10 cycles
    tn = 1;
    expect_all_off(1, 12);
    expect_at(3, S_FL, 1'b0);
    expect_at(3, S_RUN, 1'b0);
    expect_at(4, S_RUN, 1'b1);
    expect_at(13, S_AH, 1'b1);
    expect_at(13, S_AL, 1'b0);
    expect_at(13, S_BL, 1'b1);
    expect_at(13, S_BH, 1'b0);
    run(3);
    rst = 1'b0;
    run(15);

    // 2: leg A high->low with dt=10
    tn = 2; k = cyc;
    spwm_a = 1'b0;
    expect_at(k + 1, S_AH, 1'b1);
    expect_range(k + 2, k + 20, S_AH, 1'b0);
    expect_range(k + 1, k + 11, S_AL, 1'b0);
    expect_at(k + 12, S_AL, 1'b1);
    expect_at(k + 5, S_BL, 1'b1);
    run(20);

    // 3: command flips back mid-dead and dt changes mid-dead: neither shortens it
    tn = 3; k = cyc;
    spwm_a = 1'b1;
    expect_at(k + 1, S_AL, 1'b1);
    expect_range(k + 2, k + 11, S_AL, 1'b0);
    expect_at(k + 12, S_AL, 1'b1);
    expect_range(k + 1, k + 14, S_AH, 1'b0);
    run(3);
    spwm_a = 1'b0;
    dt_cycles = DT_W'(2);
    run(13);

    // 4: dt=0 behaves as one dead cycle on leg B
    tn = 4; k = cyc;
    dt_cycles = DT_W'(0);
    spwm_b = 1'b1;
    expect_at(k + 1, S_BL, 1'b1);
    expect_at(k + 2, S_BL, 1'b0);
    expect_at(k + 2, S_BH, 1'b0);
    expect_at(k + 3, S_BH, 1'b1);
    run(6);

    // 5: dt=1 gives the same single dead cycle
    tn = 5; k = cyc;
    dt_cycles = DT_W'(1);
    spwm_b = 1'b0;
    expect_at(k + 1, S_BH, 1'b1);
    expect_at(k + 2, S_BH, 1'b0);
    expect_at(k + 2, S_BL, 1'b0);
    expect_at(k + 3, S_BL, 1'b1);
    run(6);

    // 6: dt=2 sampled on the next dead entry of leg A
    tn = 6; k = cyc;
    dt_cycles = DT_W'(2);
    spwm_a = 1'b1;
    expect_at(k + 1, S_AL, 1'b1);
    expect_at(k + 2, S_AL, 1'b0);
    expect_range(k + 2, k + 3, S_AH, 1'b0);
    expect_at(k + 4, S_AH, 1'b1);
    run(6);

    // 7: en drop forces OFF next cycle; re-enable goes through DEAD
    tn = 7; k = cyc;
    dt_cycles = DT_W'(4);
    en = 1'b0;
    expect_all_off(k + 1, k + 3);
    expect_at(k + 1, S_RUN, 1'b0);
    run(3);
    k = cyc;
    en = 1'b1;
    expect_all_off(k + 1, k + 4);
    expect_at(k + 1, S_RUN, 1'b1);
    expect_at(k + 5, S_AH, 1'b1);
    expect_at(k + 5, S_BL, 1'b1);
    run(8);

    // 8: four low samples do not trip
    tn = 8; k = cyc;
    fault_n = 1'b0;
    expect_range(k + 1, k + 12, S_FL, 1'b0);
    expect_at(k + 12, S_RUN, 1'b1);
    run(4);
    fault_n = 1'b1;
    run(8);

    // 9: five low samples trip; clear while still low is ignored
    tn = 9; k = cyc;
    fault_n = 1'b0;
    expect_at(k + 5, S_FL, 1'b0);
    expect_range(k + 9, k + 14, S_FL, 1'b1);
    expect_all_off(k + 9, k + 14);
    expect_at(k + 9, S_RUN, 1'b0);
    run(10);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    run(3);

    // 10: release fault, clear after the filter settles, legs restart through DEAD
    tn = 10; k = cyc;
    fault_n = 1'b1;
    expect_at(k + 4, S_FL, 1'b1);
    expect_at(k + 5, S_FL, 1'b0);
    expect_at(k + 5, S_RUN, 1'b0);
    expect_at(k + 6, S_RUN, 1'b1);
    expect_all_off(k + 1, k + 9);
    expect_at(k + 10, S_AH, 1'b1);
    expect_at(k + 10, S_BL, 1'b1);
    run(4);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    run(8);

    // 11: random commands and enable with fixed dt, guarded by dead-time monitor
    tn = 11;
    dt_cycles = DT_W'(3);
    dead_min = 3;
    run(2);
    dt_mon = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) spwm_a = ~spwm_a;
      if ($urandom_range(7) == 0) spwm_b = ~spwm_b;
      if ($urandom_range(199) == 0) en = ~en;
      e_now = en;
      expect_at(cyc + 1, S_RUN, e_now);
      tick();
    end
    en = 1'b1;
    run(3);

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hbridge_gate_ctrl
